bitcoin_hash: RTL and testbench
===============================

// Module: bitcoin_hash
// PURPOSE
//  Bitcoin-style nonce sweep engine. It reads a 19-word (608-bit) block header from
//  word-addressed shared SRAM. For each nonce n in 0..NUM_NONCES-1 it computes
//  SHA256(SHA256(header||n)). Word 0 of each final digest (H0) goes to output_addr+n.
//  It sits as a memory-mapped co-processor beside the shared dual-port SRAM.
// PARAMETERS
//  NUM_NONCES  16  number of nonces swept (n = 0..NUM_NONCES-1); legal range 1..256
// PORTS
//  clk             in   1   sole clock; all state on posedge
//  reset_n         in   1   async reset, active-HIGH (asserted = 1; name kept per codebase)
//  start           in   1   level; rising level in IDLE/DONE starts a run; may be held >1 cycle
//  message_addr    in   16  base word address of 19-word header; sampled when start accepted
//  output_addr     in   16  base word address of results; sampled when start accepted
//  done            out  1   high when all NUM_NONCES results are written
//  mem_clk         out  1   = clk (direct assign)
//  mem_we          out  1   1 = write mem_write_data to mem_addr at next posedge mem_clk
//  mem_addr        out  16  SRAM word address (registered)
//  mem_write_data  out  32  SRAM write data (registered)
//  mem_read_data   in   32  SRAM read data, updated at posedge mem_clk from mem_addr
// BEHAVIOUR
//  Reset: done=0, mem_we=0, mem_addr=0, mem_write_data=0; FSM to IDLE, even mid-run.
//  SRAM: sync read. Address registered at edge k, memory samples at edge k+1, DUT captures at k+2.
//   Pipeline reads: one address per cycle; 19 reads take <=21 cycles.
//  Message block 1 = header words 0..15.
//  Block 2 = {hdr16, hdr17, hdr18, n, 0x80000000, 10x0, 32'd640}.
//  Hash 1 = compress(IV, blk1), then compress(midstate, blk2).
//  Hash 2 = compress(IV, {digest1[0..7], 0x80000000, 6x0, 32'd256}).
//  IV and K are the standard FIPS 180-4 SHA-256 constants. All additions are mod 2^32.
//  Rotates are right-rotates. Message words are big-endian 32-bit as stored.
//  Compression: one round per cycle, 64 rounds; W[t] from 16-entry sliding window:
//   W[t] = W[t-16] + s0(W[t-15]) + W[t-7] + s1(W[t-2]), computed on the fly.
//  Each compression takes 66 cycles: 1 load, 64 rounds, 1 final add into Hx.
//  FSM: IDLE -> READ -> BLK1 -> BLK2 -> HASH2 -> WRITE -> (next n: BLK2 | all done: DONE).
//  WRITE: one cycle, mem_we=1, mem_addr=output_addr+n, mem_write_data=H0; mem_we=0 at all other times.
//  done rises the cycle after the last write is committed to SRAM.
//  done stays high until reset or a new start is accepted, which clears it the next cycle.
//  start while busy is ignored; start held continuously across DONE does not retrigger.
//   Retrigger needs start to go low, then high.
//  Nonce counter width is $clog2(NUM_NONCES)+1 and zero-extended into word 19.
//  Address arithmetic is 16-bit and wraps modulo 2^16.
// CONFIGURATION
//  BITCOIN_HASH_MIDSTATE_EN defined: BLK1 runs once per run; midstate is held in 8x32 regs
//   and reused for every nonce. Total for 16 nonces <= 2300 cycles.
//  Not defined: BLK1 is recomputed for every nonce; no midstate regs; results are identical.
//   Total for 16 nonces <= 3400 cycles.
// STRUCTURE
//  bitcoin_hash_pkg: K[0:63], IV[0:7], rightrotate(), sha256_op() round function,
//   state enum typedef, PAD_640 / PAD_256 constants.
//  Sub-module sha256_core: load(iv, 16 words) -> 64 rounds -> digest_valid pulse + 8x32 digest.
//   The top-level FSM sequences memory, block assembly and nonce loop.
// TESTING
//  1 Reset: hold reset_n=1 for 2 cycles -> done=0, mem_we=0, mem_addr=0; no SRAM writes.
//  2 Golden run: message_addr=0, output_addr=1000, seed 0x01234567 with hdr[i]=rotl(hdr[i-1],1).
//    Check hdr[1]=0x02468ACE. Start held 2 cycles -> SRAM[1000..1015] equal software model H0[n].
//  3 Single run: start held high through completion -> exactly NUM_NONCES writes.
//    Only addresses output_addr..+15 are written; header SRAM is untouched.
//  4 Reset mid-run during HASH2 of n=5, then restart -> final results are correct and done=1 once.
//  5 Back-to-back: second start after done with output_addr=2000, new seed.
//    done drops, then rises again; both result sets are correct.
//  6 NUM_NONCES=1 and message_addr=0xFFF0 (wrap) -> one correct H0 written.
//    Cycle count is within the bound above for the chosen macro setting.

Source files
------------

// File: rtl/bitcoin_hash_pkg.sv
// bitcoin_hash_pkg: SHA-256 constants, round helpers and the sweep FSM state type.
// Shared by sha256_core and the bitcoin_hash top level.
package bitcoin_hash_pkg;

   typedef logic [31:0] word_t;
   typedef logic [7:0][31:0] hstate_t;
   typedef logic [15:0][31:0] block_t;

   typedef enum logic [2:0] {
      S_IDLE, S_READ, S_BLK1, S_BLK2, S_HASH2, S_WRITE, S_DONE
   } state_t;

   localparam word_t PAD_BIT = 32'h8000_0000;
   localparam word_t PAD_640 = 32'd640;
   localparam word_t PAD_256 = 32'd256;

   // index 0 holds H0 (a), index 7 holds H7 (h)
   localparam hstate_t IV = {
      32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
      32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
   };

   localparam word_t K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic word_t rightrotate(word_t x, int unsigned r);
      return (x >> r) | (x << (32 - r));
   endfunction

   function automatic word_t ssig0(word_t x);
      return rightrotate(x, 7) ^ rightrotate(x, 18) ^ (x >> 3);
   endfunction

   function automatic word_t ssig1(word_t x);
      return rightrotate(x, 17) ^ rightrotate(x, 19) ^ (x >> 10);
   endfunction

   function automatic hstate_t sha256_op(hstate_t s, word_t w, word_t k);
      word_t bs1, ch, t1, bs0, maj, t2;
      bs1 = rightrotate(s[4], 6) ^ rightrotate(s[4], 11)
          ^ rightrotate(s[4], 25);
      ch  = (s[4] & s[5]) ^ (~s[4] & s[6]);
      t1  = s[7] + bs1 + ch + k + w;
      bs0 = rightrotate(s[0], 2) ^ rightrotate(s[0], 13)
          ^ rightrotate(s[0], 22);
      maj = (s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]);
      t2  = bs0 + maj;
      return {s[6], s[5], s[4], s[3] + t1, s[2], s[1], s[0], t1 + t2};
   endfunction

endpackage

// File: rtl/bitcoin_hash_core.sv
// sha256_core: one SHA-256 compression, one round per cycle.
// load -> 64 rounds -> final add; digest_valid pulses once the digest is held.
module sha256_core
   import bitcoin_hash_pkg::*;
(
   input  logic    clk,
   input  logic    reset_n,
   input  logic    load,
   input  hstate_t iv,
   input  block_t  blk,
   output logic    digest_valid,
   output hstate_t digest
);

   hstate_t    s;
   hstate_t    hin;
   word_t      w [0:15];
   logic [5:0] rnd;
   logic       run;
   logic       fin;
   word_t      w_next;

   // w[0] is always W[t]; w[15] receives W[t+16]
   assign w_next = w[0] + ssig0(w[1]) + w[9] + ssig1(w[14]);
   assign digest = hin;

   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         s            <= '0;
         hin          <= '0;
         rnd          <= '0;
         run          <= 1'b0;
         fin          <= 1'b0;
         digest_valid <= 1'b0;
         for (int i = 0; i < 16; i++) w[i] <= '0;
      end else begin
         digest_valid <= 1'b0;
         if (load) begin
            s   <= iv;
            hin <= iv;
            rnd <= '0;
            run <= 1'b1;
            fin <= 1'b0;
            for (int i = 0; i < 16; i++) w[i] <= blk[i];
         end else if (run) begin
            s   <= sha256_op(s, w[0], K[rnd]);
            rnd <= rnd + 6'd1;
            for (int i = 0; i < 15; i++) w[i] <= w[i+1];
            w[15] <= w_next;
            if (rnd == 6'd63) begin
               run <= 1'b0;
               fin <= 1'b1;
            end
         end else if (fin) begin
            for (int i = 0; i < 8; i++) hin[i] <= hin[i] + s[i];
            fin          <= 1'b0;
            digest_valid <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/bitcoin_hash.sv
// bitcoin_hash: double-SHA-256 nonce sweep over a header held in shared SRAM.
// Define BITCOIN_HASH_MIDSTATE_EN to hash header block 1 once per run.
module bitcoin_hash
   import bitcoin_hash_pkg::*;
#(
   parameter int NUM_NONCES = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [15:0] message_addr,
   input  logic [15:0] output_addr,
   output logic        done,
   output logic        mem_clk,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data
);

   localparam int NW = $clog2(NUM_NONCES) + 1;

   state_t          state;
   logic            start_q;
   logic [15:0]     msg_base;
   logic [15:0]     out_base;
   logic [4:0]      rd_cnt;
   word_t           hdr [0:18];
   logic [NW-1:0]   nonce;
   logic            kick;
`ifdef BITCOIN_HASH_MIDSTATE_EN
   hstate_t         mid;
`endif

   logic    core_load;
   hstate_t core_iv;
   block_t  core_blk;
   block_t  blk1;
   block_t  blk2;
   block_t  blkh;
   hstate_t digest;
   logic    dv;

   assign mem_clk = clk;

   always_comb begin
      blk1 = '0;
      for (int i = 0; i < 16; i++) blk1[i] = hdr[i];
      blk2     = '0;
      blk2[0]  = hdr[16];
      blk2[1]  = hdr[17];
      blk2[2]  = hdr[18];
      blk2[3]  = 32'(nonce);
      blk2[4]  = PAD_BIT;
      blk2[15] = PAD_640;
      blkh     = '0;
      for (int i = 0; i < 8; i++) blkh[i] = digest[i];
      blkh[8]  = PAD_BIT;
      blkh[15] = PAD_256;
      // a finishing digest launches the next compression in the same cycle
      core_load = kick | (dv & (state == S_BLK1 || state == S_BLK2));
      core_iv   = IV;
      core_blk  = blk1;
      if (state == S_BLK1 && dv) begin
         core_iv  = digest;
         core_blk = blk2;
      end else if (state == S_BLK2 && dv) begin
         core_iv  = IV;
         core_blk = blkh;
      end else if (state == S_BLK2) begin
`ifdef BITCOIN_HASH_MIDSTATE_EN
         core_iv  = mid;
`endif
         core_blk = blk2;
      end
   end

   sha256_core u_core (
      .clk          (clk),
      .reset_n      (reset_n),
      .load         (core_load),
      .iv           (core_iv),
      .blk          (core_blk),
      .digest_valid (dv),
      .digest       (digest)
   );

   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         state          <= S_IDLE;
         start_q        <= 1'b0;
         msg_base       <= '0;
         out_base       <= '0;
         rd_cnt         <= '0;
         nonce          <= '0;
         kick           <= 1'b0;
         done           <= 1'b0;
         mem_we         <= 1'b0;
         mem_addr       <= '0;
         mem_write_data <= '0;
         for (int i = 0; i < 19; i++) hdr[i] <= '0;
`ifdef BITCOIN_HASH_MIDSTATE_EN
         mid            <= '0;
`endif
      end else begin
         start_q <= start;
         kick    <= 1'b0;
         mem_we  <= 1'b0;
         unique case (state)
            S_IDLE, S_DONE: begin
               if (start && !start_q) begin
                  msg_base <= message_addr;
                  out_base <= output_addr;
                  mem_addr <= message_addr;
                  rd_cnt   <= 5'd1;
                  nonce    <= '0;
                  done     <= 1'b0;
                  state    <= S_READ;
               end
            end
            S_READ: begin
               // data for the address issued two edges ago lands now
               if (rd_cnt < 5'd19) mem_addr <= msg_base + 16'(rd_cnt);
               if (rd_cnt >= 5'd2) hdr[rd_cnt - 5'd2] <= mem_read_data;
               rd_cnt <= rd_cnt + 5'd1;
               if (rd_cnt == 5'd20) begin
                  kick  <= 1'b1;
                  state <= S_BLK1;
               end
            end
            S_BLK1: begin
               if (dv) begin
`ifdef BITCOIN_HASH_MIDSTATE_EN
                  mid <= digest;
`endif
                  state <= S_BLK2;
               end
            end
            S_BLK2: begin
               if (dv) state <= S_HASH2;
            end
            S_HASH2: begin
               if (dv) begin
                  mem_we         <= 1'b1;
                  mem_addr       <= out_base + 16'(nonce);
                  mem_write_data <= digest[0];
                  state          <= S_WRITE;
               end
            end
            S_WRITE: begin
               if (nonce == NW'(NUM_NONCES - 1)) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  nonce <= nonce + 1'b1;
                  kick  <= 1'b1;
`ifdef BITCOIN_HASH_MIDSTATE_EN
                  state <= S_BLK2;
`else
                  state <= S_BLK1;
`endif
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bitcoin_hash.sv
// tb_bitcoin_hash: randomized nonce sweeps against a software double-SHA-256.
// Two instances: a 16-nonce sweep and a single-nonce sweep with address wrap.
module tb_bitcoin_hash;

   typedef logic [7:0][31:0]  st_t;
   typedef logic [15:0][31:0] bk_t;

   localparam logic [31:0] KT [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam st_t IVT = {
      32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
      32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
   };

`ifdef BITCOIN_HASH_MIDSTATE_EN
   localparam int BOUND = 2300;
   localparam int MIDWAIT = 100;
`else
   localparam int BOUND = 3400;
   localparam int MIDWAIT = 160;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start0, start1;
   logic [15:0] maddr0, oaddr0, maddr1, oaddr1;
   logic        done0, done1, mclk0, mclk1, we0, we1;
   logic [15:0] addr0, addr1;
   logic [31:0] wd0, wd1, rd0, rd1;

   logic [31:0] mem0 [0:65535];
   logic [31:0] mem1 [0:65535];

   logic        bd_we = 1'b0;
   logic        bd_sel = 1'b0;
   logic [15:0] bd_addr = '0;
   logic [31:0] bd_data = '0;

   int          wr0 = 0, wr1 = 0, bad0 = 0, bad1 = 0, rise0 = 0;
   logic        done0_q = 1'b0;
   logic [15:0] lo0 = '0, lo1 = '0;

   int          checks = 0, errors = 0;
   logic [31:0] hdr [0:18];
   logic [31:0] gold1k [0:15];
   logic [31:0] expv [0:15];

   bitcoin_hash #(.NUM_NONCES(16)) u_dut0 (
      .clk(clk), .reset_n(rst), .start(start0),
      .message_addr(maddr0), .output_addr(oaddr0), .done(done0),
      .mem_clk(mclk0), .mem_we(we0), .mem_addr(addr0),
      .mem_write_data(wd0), .mem_read_data(rd0)
   );

   bitcoin_hash #(.NUM_NONCES(1)) u_dut1 (
      .clk(clk), .reset_n(rst), .start(start1),
      .message_addr(maddr1), .output_addr(oaddr1), .done(done1),
      .mem_clk(mclk1), .mem_we(we1), .mem_addr(addr1),
      .mem_write_data(wd1), .mem_read_data(rd1)
   );

   always @(posedge mclk0) begin
      if (we0) begin
         mem0[addr0] <= wd0;
         wr0 <= wr0 + 1;
         if (16'(addr0 - lo0) >= 16'd16) bad0 <= bad0 + 1;
      end else if (bd_we && !bd_sel) begin
         mem0[bd_addr] <= bd_data;
      end
      rd0 <= mem0[addr0];
   end

   always @(posedge mclk1) begin
      if (we1) begin
         mem1[addr1] <= wd1;
         wr1 <= wr1 + 1;
         if (addr1 != lo1) bad1 <= bad1 + 1;
      end else if (bd_we && bd_sel) begin
         mem1[bd_addr] <= bd_data;
      end
      rd1 <= mem1[addr1];
   end

   always @(posedge clk) begin
      done0_q <= done0;
      if (done0 === 1'b1 && done0_q !== 1'b1) rise0 <= rise0 + 1;
   end

   function automatic logic [31:0] rotr(logic [31:0] x, int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic st_t compress(st_t h, bk_t m);
      logic [31:0] w [0:63];
      logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
      st_t r;
      for (int t = 0; t < 16; t++) w[t] = m[t];
      for (int t = 16; t < 64; t++) begin
         s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
         s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
         w[t] = w[t-16] + s0 + w[t-7] + s1;
      end
      a = h[0]; b = h[1]; c = h[2]; d = h[3];
      e = h[4]; f = h[5]; g = h[6]; hh = h[7];
      for (int t = 0; t < 64; t++) begin
         t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25))
            + ((e & f) ^ (~e & g)) + KT[t] + w[t];
         t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22))
            + ((a & b) ^ (a & c) ^ (b & c));
         hh = g; g = f; f = e; e = d + t1;
         d = c; c = b; b = a; a = t1 + t2;
      end
      r[0] = h[0] + a; r[1] = h[1] + b; r[2] = h[2] + c; r[3] = h[3] + d;
      r[4] = h[4] + e; r[5] = h[5] + f; r[6] = h[6] + g; r[7] = h[7] + hh;
      return r;
   endfunction

   function automatic logic [31:0] model_h0(int n);
      bk_t b;
      st_t mid, d1, d2;
      b = '0;
      for (int i = 0; i < 16; i++) b[i] = hdr[i];
      mid = compress(IVT, b);
      b = '0;
      b[0] = hdr[16]; b[1] = hdr[17]; b[2] = hdr[18];
      b[3] = 32'(n); b[4] = 32'h8000_0000; b[15] = 32'd640;
      d1 = compress(mid, b);
      b = '0;
      for (int i = 0; i < 8; i++) b[i] = d1[i];
      b[8] = 32'h8000_0000; b[15] = 32'd256;
      d2 = compress(IVT, b);
      return d2[0];
   endfunction

   task automatic bd_write(input logic sel, input logic [15:0] a,
                           input logic [31:0] d);
      @(negedge clk);
      bd_sel = sel; bd_addr = a; bd_data = d; bd_we = 1'b1;
      @(negedge clk);
      bd_we = 1'b0;
   endtask

   task automatic load_hdr(input logic sel, input logic [15:0] base,
                           input bit rnd, input logic [31:0] seed);
      for (int i = 0; i < 19; i++) begin
         if (i == 0) hdr[i] = seed;
         else if (rnd) hdr[i] = $urandom;
         else hdr[i] = {hdr[i-1][30:0], hdr[i-1][31]};
         bd_write(sel, base + 16'(i), hdr[i]);
      end
   endtask

   task automatic fill(input logic sel, input logic [15:0] base,
                       input int cnt, input logic [31:0] v);
      for (int i = 0; i < cnt; i++) bd_write(sel, base + 16'(i), v);
   endtask

   task automatic wait_done(input bit sel, input int budget, output int cyc);
      cyc = 0;
      while (((sel ? done1 : done0) !== 1'b1) && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      start0 = 0; start1 = 0;
      maddr0 = '0; oaddr0 = '0; maddr1 = '0; oaddr1 = '0;
      repeat (2) @(negedge clk);
      checks++;
      if (done0 !== 1'b0) begin
         errors++; $display("FAIL reset_done: got %b expected 0", done0);
      end
      checks++;
      if (we0 !== 1'b0) begin
         errors++; $display("FAIL reset_we: got %b expected 0", we0);
      end
      checks++;
      if (addr0 !== 16'h0) begin
         errors++; $display("FAIL reset_addr: got %h expected 0000", addr0);
      end
      checks++;
      if (wd0 !== 32'h0) begin
         errors++; $display("FAIL reset_wdata: got %h expected 0", wd0);
      end
      checks++;
      if (done1 !== 1'b0 || we1 !== 1'b0 || addr1 !== 16'h0) begin
         errors++;
         $display("FAIL reset_dut1: got done=%b we=%b addr=%h expected 0",
                  done1, we1, addr1);
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (wr0 != 0 || wr1 != 0) begin
         errors++; $display("FAIL reset_nowrite: got %0d/%0d writes expected 0",
                            wr0, wr1);
      end
   endtask

   task automatic test_golden;
      bk_t  ab;
      st_t  ad;
      int   cyc;
      int   b0;
      ab = '0; ab[0] = 32'h6162_6380; ab[15] = 32'h18;
      ad = compress(IVT, ab);
      checks++;
      if (ad[0] !== 32'hba7816bf) begin
         errors++; $display("FAIL model_abc: got %h expected ba7816bf", ad[0]);
      end
      load_hdr(1'b0, 16'h0000, 1'b0, 32'h0123_4567);
      fill(1'b0, 16'd1000, 16, 32'hDEAD_BEEF);
      for (int n = 0; n < 16; n++) gold1k[n] = model_h0(n);
      lo0 = 16'd1000; b0 = bad0;
      maddr0 = 16'h0000; oaddr0 = 16'd1000;
      start0 = 1'b1;
      repeat (2) @(negedge clk);
      start0 = 1'b0;
      wait_done(1'b0, 4000, cyc);
      cyc += 2;
      checks++;
      if (done0 !== 1'b1) begin
         errors++; $display("FAIL golden_timeout: got done=%b expected 1", done0);
      end
      checks++;
      if (cyc > BOUND) begin
         errors++; $display("FAIL golden_cycles: got %0d expected <= %0d", cyc, BOUND);
      end
      checks++;
      if (mem0[1] !== 32'h0246_8ACE) begin
         errors++; $display("FAIL golden_hdr1: got %h expected 02468ace", mem0[1]);
      end
      for (int n = 0; n < 16; n++) begin
         checks++;
         if (mem0[1000 + n] !== gold1k[n]) begin
            errors++;
            $display("FAIL golden_h0[%0d]: got %h expected %h",
                     n, mem0[1000 + n], gold1k[n]);
         end
      end
      checks++;
      if (bad0 != b0) begin
         errors++; $display("FAIL golden_addr: got %0d stray writes expected 0",
                            bad0 - b0);
      end
   endtask

   task automatic test_single_run;
      int cyc, w0, b0, miss;
      load_hdr(1'b0, 16'h0100, 1'b1, $urandom);
      fill(1'b0, 16'd3000, 16, 32'hDEAD_BEEF);
      for (int n = 0; n < 16; n++) expv[n] = model_h0(n);
      lo0 = 16'd3000; w0 = wr0; b0 = bad0;
      maddr0 = 16'h0100; oaddr0 = 16'd3000;
      start0 = 1'b1;
      @(negedge clk);
      wait_done(1'b0, 4000, cyc);
      repeat (20) @(negedge clk);
      checks++;
      if (done0 !== 1'b1) begin
         errors++; $display("FAIL single_done_held: got %b expected 1", done0);
      end
      checks++;
      if (wr0 - w0 != 16) begin
         errors++; $display("FAIL single_writes: got %0d expected 16", wr0 - w0);
      end
      checks++;
      if (bad0 != b0) begin
         errors++; $display("FAIL single_addr: got %0d stray writes expected 0",
                            bad0 - b0);
      end
      miss = 0;
      for (int i = 0; i < 19; i++)
         if (mem0[16'h0100 + i] !== hdr[i]) miss++;
      checks++;
      if (miss != 0) begin
         errors++; $display("FAIL single_hdr_intact: got %0d changed expected 0", miss);
      end
      for (int n = 0; n < 16; n++) begin
         checks++;
         if (mem0[3000 + n] !== expv[n]) begin
            errors++;
            $display("FAIL single_h0[%0d]: got %h expected %h",
                     n, mem0[3000 + n], expv[n]);
         end
      end
      start0 = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_midrun;
      int cyc, w0, r0;
      load_hdr(1'b0, 16'h0200, 1'b1, $urandom);
      for (int n = 0; n < 16; n++) expv[n] = model_h0(n);
      lo0 = 16'd4000; w0 = wr0;
      maddr0 = 16'h0200; oaddr0 = 16'd4000;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      cyc = 0;
      while (wr0 - w0 < 5 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (wr0 - w0 < 5) begin
         errors++; $display("FAIL midrun_progress: got %0d writes expected 5",
                            wr0 - w0);
      end
      repeat (MIDWAIT) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (done0 !== 1'b0 || we0 !== 1'b0 || addr0 !== 16'h0) begin
         errors++;
         $display("FAIL midrun_reset: got done=%b we=%b addr=%h expected 0",
                  done0, we0, addr0);
      end
      rst = 1'b0;
      fill(1'b0, 16'd4000, 16, 32'hDEAD_BEEF);
      w0 = wr0; r0 = rise0;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      wait_done(1'b0, 4000, cyc);
      repeat (10) @(negedge clk);
      checks++;
      if (rise0 - r0 != 1) begin
         errors++; $display("FAIL midrun_done_once: got %0d rises expected 1",
                            rise0 - r0);
      end
      checks++;
      if (wr0 - w0 != 16) begin
         errors++; $display("FAIL midrun_writes: got %0d expected 16", wr0 - w0);
      end
      for (int n = 0; n < 16; n++) begin
         checks++;
         if (mem0[4000 + n] !== expv[n]) begin
            errors++;
            $display("FAIL midrun_h0[%0d]: got %h expected %h",
                     n, mem0[4000 + n], expv[n]);
         end
      end
   endtask

   task automatic test_back_to_back;
      int cyc;
      load_hdr(1'b0, 16'h0300, 1'b1, $urandom);
      fill(1'b0, 16'd2000, 16, 32'hDEAD_BEEF);
      for (int n = 0; n < 16; n++) expv[n] = model_h0(n);
      lo0 = 16'd2000;
      checks++;
      if (done0 !== 1'b1) begin
         errors++; $display("FAIL b2b_done_before: got %b expected 1", done0);
      end
      maddr0 = 16'h0300; oaddr0 = 16'd2000;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      checks++;
      if (done0 !== 1'b0) begin
         errors++; $display("FAIL b2b_done_drop: got %b expected 0", done0);
      end
      wait_done(1'b0, 4000, cyc);
      checks++;
      if (done0 !== 1'b1) begin
         errors++; $display("FAIL b2b_timeout: got done=%b expected 1", done0);
      end
      for (int n = 0; n < 16; n++) begin
         checks++;
         if (mem0[2000 + n] !== expv[n] || mem0[1000 + n] !== gold1k[n]) begin
            errors++;
            $display("FAIL b2b_h0[%0d]: got %h/%h expected %h/%h", n,
                     mem0[2000 + n], mem0[1000 + n], expv[n], gold1k[n]);
         end
      end
   endtask

   task automatic test_wrap;
      int cyc;
      logic [31:0] e0;
      load_hdr(1'b1, 16'hFFF0, 1'b1, $urandom);
      fill(1'b1, 16'h0500, 2, 32'hDEAD_BEEF);
      e0 = model_h0(0);
      lo1 = 16'h0500;
      maddr1 = 16'hFFF0; oaddr1 = 16'h0500;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      wait_done(1'b1, 4000, cyc);
      cyc += 1;
      checks++;
      if (done1 !== 1'b1) begin
         errors++; $display("FAIL wrap_timeout: got done=%b expected 1", done1);
      end
      checks++;
      if (cyc > BOUND) begin
         errors++; $display("FAIL wrap_cycles: got %0d expected <= %0d", cyc, BOUND);
      end
      checks++;
      if (mem1[16'h0500] !== e0) begin
         errors++; $display("FAIL wrap_h0: got %h expected %h", mem1[16'h0500], e0);
      end
      checks++;
      if (wr1 != 1 || bad1 != 0 || mem1[16'h0501] !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL wrap_writes: got %0d writes %0d stray expected 1/0",
                  wr1, bad1);
      end
   endtask

   initial begin
      test_reset;
      test_golden;
      test_single_run;
      test_reset_midrun;
      test_back_to_back;
      test_wrap;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
